// File: rtl/cpu_pkg.sv
// Shared CPU constants and the fetch buffer entry type.
package cpu_pkg;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Fetch addresses are word aligned; the low byte-offset bits are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction memory port, redirect input and decode-side handshake of the fetch stage.
interface inst_fetch_if;
  import cpu_pkg::*;

  logic [31:0]        instruction_addr;
  logic [INSTR_W-1:0] instruction;
  logic               redirect_valid;
  logic [31:0]        redirect_target;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [31:0]        out_pc;

  modport master (
    output instruction_addr, out_valid, out_instr, out_pc,
    input  instruction, redirect_valid, redirect_target, out_ready
  );

  modport slave (
    input  instruction_addr, out_valid, out_instr, out_pc,
    output instruction, redirect_valid, redirect_target, out_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch buffer: circular FIFO of fetch entries with flush and a registered head.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  fetch_entry_t               push_entry,
  input  logic                       pop,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count,
  output fetch_entry_t               head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Flush wins over everything; the caller never pushes into a full buffer without a pop.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: owns the fetch PC, pushes fetched words into the prefetch buffer, handles redirects.
module inst_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BUF_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  inst_fetch_if.master  bus
);

  localparam int               CNT_W    = $clog2(BUF_DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0] fifo_count;
  fetch_entry_t     head_entry;
  fetch_entry_t     push_entry;
  logic             push, pop, flush, has_entry;

  assign has_entry = (fifo_count != '0);
  assign pop       = has_entry && bus.out_ready;

  // A redirect discards the word being fetched this cycle; a pop in the same cycle still completes.
  always_comb begin
    flush            = bus.redirect_valid;
    push             = !bus.redirect_valid && ((fifo_count < FULL_CNT) || pop);
    push_entry.pc    = fetch_pc_q;
    push_entry.instr = bus.instruction;
    fetch_pc_d       = fetch_pc_q;
    if (bus.redirect_valid) begin
      fetch_pc_d = align_pc(bus.redirect_target);
    end else if (push) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
    end else begin
      fetch_pc_q <= fetch_pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (flush),
    .count      (fifo_count),
    .head       (head_entry)
  );

  assign bus.instruction_addr = fetch_pc_q;
  assign bus.out_valid        = has_entry;
  assign bus.out_instr        = head_entry.instr;
  assign bus.out_pc           = head_entry.pc;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: memory word at address a is a>>2, scoreboard of expected out_pc values.
module tb_inst_fetch;
  import cpu_pkg::*;

  logic        clk;
  logic        rst_n;
  int          n_checks;
  int          n_fail;
  logic [31:0] exp_q[$];

  inst_fetch_if bus ();

  inst_fetch #(
    .RESET_PC  (32'h0000_0000),
    .BUF_DEPTH (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.instruction = bus.instruction_addr >> 2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Holds reset for two cycles, leaving the bench at a negedge with rst_n still low.
  task automatic do_reset();
    rst_n               = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = 32'h0;
    bus.out_ready       = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n               = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = 32'h0;
    bus.out_ready       = 1'b1;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.out_valid);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_valid_clocked: got %b expected 0", bus.out_valid);
    end
    n_checks++;
    if (bus.out_pc !== 32'h0) begin
      n_fail++; $display("[TB] FAIL reset_pc: got %h expected 00000000", bus.out_pc);
    end
    n_checks++;
    if (bus.out_instr !== 32'h0) begin
      n_fail++; $display("[TB] FAIL reset_instr: got %h expected 00000000", bus.out_instr);
    end
    n_checks++;
    if (bus.instruction_addr !== 32'h0) begin
      n_fail++; $display("[TB] FAIL reset_addr: got %h expected 00000000", bus.instruction_addr);
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    int budget;
    do_reset();
    bus.out_ready = 1'b1;
    rst_n         = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
    budget = 0;
    while (exp_q.size() != 0 && budget < 40) begin
      budget++;
      exp_pc = exp_q.pop_front();
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_pc) begin
        n_fail++; $display("[TB] FAIL stream_pc: got %h valid %b expected %h", bus.out_pc, bus.out_valid, exp_pc);
      end
      n_checks++;
      if (bus.out_instr !== (exp_pc >> 2)) begin
        n_fail++; $display("[TB] FAIL stream_instr: got %h expected %h", bus.out_instr, exp_pc >> 2);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc;
    do_reset();
    bus.out_ready = 1'b0;
    rst_n         = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0 || bus.out_instr !== 32'h0) begin
        n_fail++;
        $display("[TB] FAIL stall_head: got valid %b pc %h instr %h expected 1 00000000 00000000",
                 bus.out_valid, bus.out_pc, bus.out_instr);
      end
    end
    n_checks++;
    if (bus.instruction_addr !== 32'h8) begin
      n_fail++; $display("[TB] FAIL stall_addr: got %h expected 00000008", bus.instruction_addr);
    end
    n_checks++;
    if (dut.fifo_count !== 2'd2) begin
      n_fail++; $display("[TB] FAIL stall_count: got %0d expected 2", dut.fifo_count);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(i * 4));
    for (int b = 0; b < 40 && exp_q.size() != 0; b++) begin
      exp_pc = exp_q.pop_front();
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_pc || bus.out_instr !== (exp_pc >> 2)) begin
        n_fail++;
        $display("[TB] FAIL drain_after_stall: got valid %b pc %h instr %h expected pc %h",
                 bus.out_valid, bus.out_pc, bus.out_instr, exp_pc);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_redirect();
    logic [31:0] exp_pc;
    int budget;
    do_reset();
    bus.out_ready = 1'b1;
    rst_n         = 1'b1;
    @(negedge clk);
    budget = 0;
    while (bus.out_pc !== 32'h10 && budget < 20) begin
      budget++;
      @(negedge clk);
    end
    n_checks++;
    if (bus.out_pc !== 32'h10 || bus.out_valid !== 1'b1) begin
      n_fail++; $display("[TB] FAIL redirect_head: got pc %h valid %b expected 00000010", bus.out_pc, bus.out_valid);
    end
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h103;
    @(negedge clk);
    bus.redirect_valid  = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL redirect_bubble: got valid %b pc %h expected 0", bus.out_valid, bus.out_pc);
    end
    n_checks++;
    if (bus.instruction_addr !== 32'h100) begin
      n_fail++; $display("[TB] FAIL redirect_addr: got %h expected 00000100", bus.instruction_addr);
    end
    @(negedge clk);
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    exp_q.push_back(32'h108);
    for (int b = 0; b < 40 && exp_q.size() != 0; b++) begin
      exp_pc = exp_q.pop_front();
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_pc || bus.out_instr !== (exp_pc >> 2)) begin
        n_fail++;
        $display("[TB] FAIL redirect_stream: got valid %b pc %h instr %h expected pc %h",
                 bus.out_valid, bus.out_pc, bus.out_instr, exp_pc);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_pc;
    do_reset();
    bus.out_ready = 1'b1;
    rst_n         = 1'b1;
    repeat (3) @(negedge clk);
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h40;
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL b2b_bubble1: got valid %b pc %h expected 0", bus.out_valid, bus.out_pc);
    end
    bus.redirect_target = 32'h80;
    @(negedge clk);
    bus.redirect_valid  = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL b2b_bubble2: got valid %b pc %h expected 0", bus.out_valid, bus.out_pc);
    end
    @(negedge clk);
    exp_q.push_back(32'h80);
    exp_q.push_back(32'h84);
    for (int b = 0; b < 40 && exp_q.size() != 0; b++) begin
      exp_pc = exp_q.pop_front();
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_pc || bus.out_instr !== (exp_pc >> 2)) begin
        n_fail++;
        $display("[TB] FAIL b2b_stream: got valid %b pc %h instr %h expected pc %h",
                 bus.out_valid, bus.out_pc, bus.out_instr, exp_pc);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc;
    do_reset();
    bus.out_ready = 1'b1;
    rst_n         = 1'b1;
    @(negedge clk);
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'hFFFF_FFF8;
    @(negedge clk);
    bus.redirect_valid  = 1'b0;
    @(negedge clk);
    exp_q.push_back(32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000);
    exp_q.push_back(32'h0000_0004);
    for (int b = 0; b < 40 && exp_q.size() != 0; b++) begin
      exp_pc = exp_q.pop_front();
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_pc || bus.out_instr !== (exp_pc >> 2)) begin
        n_fail++;
        $display("[TB] FAIL wrap_stream: got valid %b pc %h instr %h expected pc %h",
                 bus.out_valid, bus.out_pc, bus.out_instr, exp_pc);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] exp_pc;
    do_reset();
    bus.out_ready = 1'b0;
    rst_n         = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.instruction_addr !== 32'h8) begin
      n_fail++; $display("[TB] FAIL areset_full: got valid %b addr %h expected 1 00000008", bus.out_valid, bus.instruction_addr);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL areset_valid: got %b expected 0", bus.out_valid);
    end
    n_checks++;
    if (bus.out_pc !== 32'h0 || bus.out_instr !== 32'h0 || bus.instruction_addr !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL areset_regs: got pc %h instr %h addr %h expected all 00000000",
               bus.out_pc, bus.out_instr, bus.instruction_addr);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    rst_n         = 1'b1;
    @(negedge clk);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    for (int b = 0; b < 40 && exp_q.size() != 0; b++) begin
      exp_pc = exp_q.pop_front();
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_pc || bus.out_instr !== (exp_pc >> 2)) begin
        n_fail++;
        $display("[TB] FAIL areset_restart: got valid %b pc %h instr %h expected pc %h",
                 bus.out_valid, bus.out_pc, bus.out_instr, exp_pc);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_back_to_back();
    test_wrap();
    test_async_reset();
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, default 2, prefetch buffer entries (power of two, >=2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 instruction_addr  output  32  byte address presented to the instruction memory.
REQ-006 instruction  input  32  instruction word returned combinationally for instruction_addr in the same cycle.
REQ-007 redirect_valid  input  1  branch/jump taken; redirect fetch this cycle.
REQ-008 redirect_target  input  32  new byte fetch address, valid with redirect_valid.
REQ-009 out_valid  output  1  out_instr/out_pc hold a fetched instruction.
REQ-010 out_ready  input  1  decode stage accepts the current output.
REQ-011 out_instr  output  32  instruction word at buffer head.
REQ-012 out_pc  output  32  byte address of out_instr.

Function
REQ-013 fetch_pc register SHALL drive instruction_addr directly, with no combinational dependence on any input.
REQ-014 Push condition: no redirect_valid, and (count < BUF_DEPTH, or a pop occurs in the same cycle).
REQ-015 On push, {fetch_pc, instruction} SHALL be written to the buffer tail and fetch_pc SHALL advance by 4.
REQ-016 fetch_pc SHALL wrap modulo 2^32: 32'hFFFF_FFFC + 4 -> 32'h0000_0000.
REQ-017 Pop occurs when out_valid && out_ready; the head entry is removed and counts as consumed.
REQ-018 out_valid = (count != 0); out_instr/out_pc SHALL come from the head entry only, as registered storage.
REQ-019 Push and pop in the same cycle SHALL leave count unchanged, including when count == BUF_DEPTH, sustaining 1 instruction/cycle.
REQ-020 out_instr/out_pc SHALL remain stable while out_valid && !out_ready.
REQ-021 Redirect has priority over push.
REQ-022 Redirect cycle, buffer: all entries SHALL be flushed (count -> 0).
REQ-023 Redirect cycle, fetch_pc: SHALL load {redirect_target[31:2], 2'b00}.
REQ-024 Redirect cycle, push: the word currently fetched SHALL be discarded.
REQ-025 A pop in the redirect cycle SHALL complete normally, so the consumed instruction is not lost.
REQ-026 Redirect latency: fetch_pc = target on the next edge; out_valid with out_pc = aligned target one further edge later (2 cycles after redirect assertion).
REQ-027 Back-to-back redirects SHALL each take effect; only the latest target is fetched.
REQ-028 Count SHALL never exceed BUF_DEPTH and never underflow.
REQ-029 Pop with count == 0 SHALL be impossible because out_valid is 0.

Reset
REQ-030 While rst_n == 0: fetch_pc = RESET_PC, count = 0, read/write pointers = 0, out_valid = 0.
REQ-031 While rst_n == 0, out_instr and out_pc SHALL be 32'h0.
REQ-032 Reset asserted mid-operation SHALL immediately discard all buffered entries, with no partial push.
REQ-033 First edge after rst_n release SHALL push RESET_PC's word; out_valid = 1 after that edge.

Structure
REQ-034 Shared package cpu_pkg SHALL hold the RESET_PC default constant, the instruction width (32), and typedef fetch_entry_t {pc[31:0], instr[31:0]}.
REQ-035 Buffer SHALL be a sub-module fetch_fifo with push, pop, flush, count, and a head-entry port.
REQ-036 fetch_fifo SHALL be parameterised by BUF_DEPTH; inst_fetch owns fetch_pc and the push/redirect control.

Verification
REQ-037 Reset release, out_ready=1, memory word[i]=i: out_pc sequence 0x0,0x4,0x8,... on consecutive cycles; out_instr = out_pc>>2.
REQ-038 out_ready=0 for 5 cycles after reset: count saturates at 2, fetch_pc stalls at 0x8, head stays pc 0x0; with out_ready=1, pcs 0x0,0x4,0x8 follow without gaps.
REQ-039 Redirect to 0x103 while head is pc 0x10 and out_ready=1: 0x10 consumed, 0x14 flushed; next valid out_pc = 0x100, then 0x104.
REQ-040 Redirect on two consecutive cycles (0x40 then 0x80): no entry from 0x40 appears; first valid out_pc = 0x80.
REQ-041 fetch_pc forced via redirect to 0xFFFF_FFF8: out_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
REQ-042 rst_n asserted asynchronously mid-cycle with buffer full: out_valid drops immediately; after release, out_pc restarts at RESET_PC.
